// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with a shared edge- or center-aligned period counter.
// Each channel has its own duty compare and polarity. Configuration is double-buffered
// and only reaches the counter and comparators at period boundaries.
module pwm_multi_channel #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [WIDTH-1:0]        period,
    input  logic [NUM_CH*WIDTH-1:0] duty,
    input  logic                    center_mode,
    input  logic [NUM_CH-1:0]       polarity,
    input  logic                    cfg_load,
    output logic                    cfg_pending,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    cycle_start
);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    typedef struct packed {
        logic [WIDTH-1:0]        period;
        logic [NUM_CH*WIDTH-1:0] duty;
        logic                    center;
        logic [NUM_CH-1:0]       pol;
    } cfg_t;

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    cfg_t               shadow_q, shadow_d;
    cfg_t               active_q, active_d;
    cfg_t               cfg_in;
    logic               pending_q, pending_d;
    logic [NUM_CH-1:0]  pwm_q, pwm_d;
    logic [NUM_CH-1:0]  raw;
    logic               apply;

    always_comb begin
        cfg_in.period = period;
        cfg_in.duty   = duty;
        cfg_in.center = center_mode;
        cfg_in.pol    = polarity;
    end

    // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                dir_d = DIR_UP;
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    dir_d   = DIR_UP;
                end else if (!active_q.center) begin
                    cnt_d = (cnt_q >= active_q.period) ? '0 : cnt_q + 1'b1;
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q < active_q.period) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (active_q.period != '0) begin
                        // Turn around at the top; with P=1 the down leg is empty.
                        cnt_d = cnt_q - 1'b1;
                        dir_d = (cnt_q == WIDTH'(1)) ? DIR_UP : DIR_DOWN;
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    if (cnt_q <= WIDTH'(1)) begin
                        cnt_d = '0;
                        dir_d = DIR_UP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // In RUN the counter only lands on 0 at a wrap, the P=0 self-loop or an abort.
    assign apply = (state_q == ST_IDLE) || (cnt_d == '0);

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (cfg_load) shadow_d = cfg_in;
        if (apply) begin
            active_d  = cfg_load ? cfg_in : shadow_q;
            pending_d = 1'b0;
        end else if (cfg_load) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            raw[i] = (state_q == ST_RUN) && (cnt_q < active_q.duty[i*WIDTH +: WIDTH]);
        end
        pwm_d = raw ^ active_q.pol;
    end

    // NOTE: sequential state uses non-blocking assignments only; the config registers
    // are reset along with the counter so the block always starts from P=0, duty=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            cnt_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            pwm_q     <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
        end
    end

    assign cfg_pending = pending_q;
    assign pwm_out     = pwm_q;
    assign cycle_start = (state_q == ST_RUN) && (cnt_q == '0);

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed testbench for pwm_multi_channel (WIDTH=8, NUM_CH=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_multi_channel;

    localparam int W = 8;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic [W-1:0]   period;
    logic [N*W-1:0] duty;
    logic           center_mode;
    logic [N-1:0]   polarity;
    logic           cfg_load;
    logic           cfg_pending;
    logic [N-1:0]   pwm_out;
    logic           cycle_start;

    int total = 0;
    int bad   = 0;

    pwm_multi_channel #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .period      (period),
        .duty        (duty),
        .center_mode (center_mode),
        .polarity    (polarity),
        .cfg_load    (cfg_load),
        .cfg_pending (cfg_pending),
        .pwm_out     (pwm_out),
        .cycle_start (cycle_start)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Used while the block is idle, where a load is applied immediately.
    task automatic load_cfg(input logic [W-1:0] p, input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic cm, input logic [N-1:0] pol);
        period      = p;
        duty        = {d1, d0};
        center_mode = cm;
        polarity    = pol;
        cfg_load    = 1'b1;
        tick();
        cfg_load    = 1'b0;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; period = '0; duty = '0;
        center_mode = 1'b0; polarity = '0; cfg_load = 1'b0;
        #1;
        total++; if (pwm_out !== 2'b00) begin bad++; $display("FAIL reset_pwm got=%b exp=00", pwm_out); end
        total++; if (cycle_start !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b exp=0", cycle_start); end
        total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", cfg_pending); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_edge();
        logic [N-1:0] exp_pwm;
        load_cfg(8'd9, 8'd3, 8'd10, 1'b0, 2'b00);
        total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL edge_idle_load_pending got=%b exp=0", cfg_pending); end
        enable = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            exp_pwm = (i == 0) ? 2'b00 : {1'b1, ((i - 1) % 10) < 3};
            total++; if (cycle_start !== (i % 10 == 0)) begin bad++; $display("FAIL edge_cs i=%0d got=%b exp=%b", i, cycle_start, (i % 10 == 0)); end
            total++; if (pwm_out !== exp_pwm) begin bad++; $display("FAIL edge_pwm i=%0d got=%b exp=%b", i, pwm_out, exp_pwm); end
            tick();
        end
        go_idle();
    endtask

    task automatic test_center();
        int seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
        int highs = 0;
        logic [N-1:0] exp_pwm;
        load_cfg(8'd4, 8'd2, 8'd0, 1'b1, 2'b00);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            exp_pwm = (i == 0) ? 2'b00 : {1'b0, seq[(i - 1) % 8] < 2};
            total++; if (cycle_start !== (seq[i % 8] == 0)) begin bad++; $display("FAIL center_cs i=%0d got=%b", i, cycle_start); end
            total++; if (pwm_out !== exp_pwm) begin bad++; $display("FAIL center_pwm i=%0d got=%b exp=%b", i, pwm_out, exp_pwm); end
            if (i >= 1 && i <= 8) highs += int'(pwm_out[0]);
            tick();
        end
        total++; if (highs != 3) begin bad++; $display("FAIL center_high_count got=%0d exp=3", highs); end
        go_idle();
    endtask

    task automatic test_shadow();
        int hi1 = 0;
        int hi2 = 0;
        logic exp_pend;
        logic exp_p0;
        load_cfg(8'd9, 8'd3, 8'd0, 1'b0, 2'b00);
        enable = 1'b1;
        tick();
        for (int i = 0; i <= 20; i++) begin
            exp_pend = (i >= 6 && i <= 9);
            exp_p0   = (i == 0) ? 1'b0 :
                       ((i - 1) < 10) ? (((i - 1) % 10) < 3) : (((i - 1) % 10) < 6);
            total++; if (cfg_pending !== exp_pend) begin bad++; $display("FAIL shadow_pending i=%0d got=%b exp=%b", i, cfg_pending, exp_pend); end
            total++; if (pwm_out !== {1'b0, exp_p0}) begin bad++; $display("FAIL shadow_pwm i=%0d got=%b exp=%b", i, pwm_out, {1'b0, exp_p0}); end
            if (i >= 1 && i <= 10) hi1 += int'(pwm_out[0]);
            if (i >= 11 && i <= 20) hi2 += int'(pwm_out[0]);
            if (i == 5) begin
                duty     = {8'd0, 8'd6};
                cfg_load = 1'b1;
            end else begin
                cfg_load = 1'b0;
            end
            tick();
        end
        total++; if (hi1 != 3) begin bad++; $display("FAIL shadow_old_period_high got=%0d exp=3", hi1); end
        total++; if (hi2 != 6) begin bad++; $display("FAIL shadow_new_period_high got=%0d exp=6", hi2); end
        go_idle();
    endtask

    task automatic test_abort();
        load_cfg(8'd9, 8'd0, 8'd0, 1'b0, 2'b01);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if (pwm_out !== 2'b01) begin bad++; $display("FAIL abort_run_pwm i=%0d got=%b exp=01", i, pwm_out); end
            if (i < 4) tick();
        end
        enable = 1'b0;
        tick();
        total++; if (cycle_start !== 1'b0) begin bad++; $display("FAIL abort_cs got=%b exp=0", cycle_start); end
        total++; if (pwm_out !== 2'b01) begin bad++; $display("FAIL abort_pwm0 got=%b exp=01", pwm_out); end
        tick();
        total++; if (pwm_out !== 2'b01) begin bad++; $display("FAIL abort_pwm1 got=%b exp=01", pwm_out); end
    endtask

    task automatic test_back_to_back_wrap_load();
        int cnt_i;
        int cp;
        int dv;
        logic [N-1:0] exp_pwm;
        load_cfg(8'd4, 8'd2, 8'd0, 1'b0, 2'b00);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            cnt_i = (i < 5) ? i : (i - 5) % 3;
            if (i == 0) begin
                exp_pwm = 2'b00;
            end else begin
                cp = ((i - 1) < 5) ? (i - 1) : ((i - 6) % 3);
                dv = ((i - 1) < 5) ? 2 : 1;
                exp_pwm = {1'b0, cp < dv};
            end
            total++; if (cycle_start !== (cnt_i == 0)) begin bad++; $display("FAIL wrap_cs i=%0d got=%b exp=%b", i, cycle_start, (cnt_i == 0)); end
            total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL wrap_pending i=%0d got=%b exp=0", i, cfg_pending); end
            total++; if (pwm_out !== exp_pwm) begin bad++; $display("FAIL wrap_pwm i=%0d got=%b exp=%b", i, pwm_out, exp_pwm); end
            if (i == 4) begin
                period   = 8'd2;
                duty     = {8'd0, 8'd1};
                cfg_load = 1'b1;
            end else begin
                cfg_load = 1'b0;
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        load_cfg(8'd9, 8'd5, 8'd10, 1'b0, 2'b00);
        enable = 1'b1;
        tick();
        tick();
        total++; if (pwm_out !== 2'b11) begin bad++; $display("FAIL rstmid_pre_pwm got=%b exp=11", pwm_out); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (pwm_out !== 2'b00) begin bad++; $display("FAIL rstmid_pwm got=%b exp=00", pwm_out); end
        total++; if (cycle_start !== 1'b0) begin bad++; $display("FAIL rstmid_cs got=%b exp=0", cycle_start); end
        total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL rstmid_pending got=%b exp=0", cfg_pending); end
        #2 rst_n = 1'b1;
        tick();
        // Active config is all-zero: P=0 self-loop, both outputs low.
        for (int i = 0; i < 3; i++) begin
            total++; if (cycle_start !== 1'b1) begin bad++; $display("FAIL rstmid_zero_cs i=%0d got=%b exp=1", i, cycle_start); end
            total++; if (pwm_out !== 2'b00) begin bad++; $display("FAIL rstmid_zero_pwm i=%0d got=%b exp=00", i, pwm_out); end
            tick();
        end
        period   = 8'd9;
        duty     = {8'd0, 8'd3};
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL rstmid_reload_pending got=%b exp=0", cfg_pending); end
        total++; if (cycle_start !== 1'b1) begin bad++; $display("FAIL rstmid_reload_cs0 got=%b exp=1", cycle_start); end
        tick();
        total++; if (cycle_start !== 1'b0) begin bad++; $display("FAIL rstmid_reload_cs1 got=%b exp=0", cycle_start); end
        total++; if (pwm_out !== 2'b01) begin bad++; $display("FAIL rstmid_reload_pwm got=%b exp=01", pwm_out); end
        go_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_shadow();
        test_abort();
        test_back_to_back_wrap_load();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
